// File: rtl/tron_trail_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tron_trail_mem_ctrl
//
// Trail memory controller for a multi-player TRON arena. Move requests from
// the players are arbitrated round-robin. Each granted move does a
// read-check-write on the trail RAM:
//   - an occupied cell raises the player's sticky collision flag;
//   - a free cell is stamped with the player ID (index + 1).
// An optional sweep zeroes the whole arena between rounds.
//
// Optional feature macro: TRON_TRAIL_CLEAR_EN
//   defined   -> CLEAR state present; clear_start launches a full-arena sweep
//   undefined -> no CLEAR state; clear_start ignored; busy tied to 0
//
// Ports
//   clk, resetn      rising-edge clock, asynchronous active-low reset
//   req              per-player move request, held until ack
//   pos_x, pos_y     packed per-player coordinates (player i at [i*W +: W])
//   ack              one-cycle completion pulse per player
//   collision        sticky per-player collision flag
//   clear_start      one-cycle sweep request
//   busy             high while a sweep is running
//   mem_addr         {x, y} zero-extended to ADDR_W, or sweep address
//   mem_re / mem_we  one-cycle read / write strobes (never both)
//   mem_wdata        write data (player ID, or 0 during a sweep)
//   mem_rdata        read data, valid RD_LAT cycles after the mem_re cycle
// -----------------------------------------------------------------------------

// Per-player lane: owns the sticky collision flag and decodes the ack pulse.
module tron_trail_lane (
    input  logic clk,
    input  logic resetn,
    input  logic sel,        // this lane holds the current grant
    input  logic commit,     // controller is in its ack/commit cycle
    input  logic hit,        // the checked cell was occupied
    input  logic clr_all,    // sweep finished: drop all flags
    output logic ack,
    output logic collision
);
    logic coll_q, coll_d;

    always_comb begin
        coll_d = coll_q;
        if (clr_all) begin
            coll_d = 1'b0;
        end else if (sel && commit && hit) begin
            coll_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign ack       = sel & commit;
    assign collision = coll_q;
endmodule

module tron_trail_mem_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_PLAYERS-1:0]     req,
    input  logic [NUM_PLAYERS*X_W-1:0] pos_x,
    input  logic [NUM_PLAYERS*Y_W-1:0] pos_y,
    output logic [NUM_PLAYERS-1:0]     ack,
    output logic [NUM_PLAYERS-1:0]     collision,
    input  logic                       clear_start,
    output logic                       busy,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_re,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int CW = X_W + Y_W;
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CHECK,
        WRITE
`ifdef TRON_TRAIL_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   gnt_q, gnt_d;     // player being serviced
    logic [PW-1:0]   ptr_q, ptr_d;     // highest-priority index for next grant
    logic [CW-1:0]   addr_q, addr_d;   // latched {x, y} of the grant
    logic [WW-1:0]   wcnt_q, wcnt_d;   // cycles spent in WAIT
    logic            hit_q, hit_d;     // checked cell was occupied

    logic            commit;
    logic            clr_all;

    // ---------------------------------------------------------------------
    // Round-robin pick: rotate the doubled request vector so that ptr_q lands
    // on bit 0, then take the first set bit.
    // ---------------------------------------------------------------------
    logic [2*NUM_PLAYERS-1:0] req2;
    logic [2*NUM_PLAYERS-1:0] req_rot;
    logic                     found;
    int                       sel_i;
    logic [CW-1:0]            sel_addr;

    assign req2    = {req, req};
    assign req_rot = req2 >> ptr_q;

    always_comb begin
        found = 1'b0;
        sel_i = 0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                sel_i = int'(ptr_q) + i;
                if (sel_i >= NUM_PLAYERS) begin
                    sel_i = sel_i - NUM_PLAYERS;
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (sel_i == j) begin
                sel_addr = {pos_x[j*X_W +: X_W], pos_y[j*Y_W +: Y_W]};
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sweep bookkeeping
    // ---------------------------------------------------------------------
    logic clr_go;
`ifdef TRON_TRAIL_CLEAR_EN
    logic [CW-1:0] clr_addr_q, clr_addr_d;
    logic          clr_pend_q, clr_pend_d;

    // A clear_start seen mid-transaction is parked until the next IDLE; one
    // seen while the sweep runs is dropped.
    always_comb begin
        clr_pend_d = clr_pend_q;
        if (state_q == IDLE || state_q == CLEAR) begin
            clr_pend_d = 1'b0;
        end else if (clear_start) begin
            clr_pend_d = 1'b1;
        end
    end

    assign clr_go = clear_start | clr_pend_q;
`else
    logic unused_clear_start;
    assign unused_clear_start = clear_start;
    assign clr_go             = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Next-state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wcnt_d    = wcnt_q;
        hit_d     = hit_q;
        commit    = 1'b0;
        clr_all   = 1'b0;
        busy      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef TRON_TRAIL_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif

        case (state_q)
            IDLE: begin
                if (clr_go) begin
`ifdef TRON_TRAIL_CLEAR_EN
                    state_d    = CLEAR;
                    clr_addr_d = '0;
`endif
                end else if (found) begin
                    gnt_d   = PW'(sel_i);
                    ptr_d   = (sel_i == NUM_PLAYERS - 1) ? '0 : PW'(sel_i + 1);
                    addr_d  = sel_addr;
                    state_d = READ;
                end
            end

            READ: begin
                mem_re   = 1'b1;
                mem_addr = ADDR_W'(addr_q);
                wcnt_d   = '0;
                state_d  = (RD_LAT > 1) ? WAIT : CHECK;
            end

            // Pads the read latency so CHECK lands on the rdata-valid cycle.
            WAIT: begin
                if (wcnt_q == WW'(RD_LAT - 2)) begin
                    state_d = CHECK;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end

            CHECK: begin
                hit_d   = (mem_rdata != '0);
                state_d = WRITE;
            end

            // Commit cycle for both outcomes: the ack always lands here so
            // every move takes the same number of cycles; the write itself
            // is suppressed when the cell was occupied.
            WRITE: begin
                commit    = 1'b1;
                mem_we    = ~hit_q;
                mem_addr  = ADDR_W'(addr_q);
                mem_wdata = DATA_W'(gnt_q) + DATA_W'(1);
                state_d   = IDLE;
            end

`ifdef TRON_TRAIL_CLEAR_EN
            CLEAR: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ADDR_W'(clr_addr_q);
                if (clr_addr_q == {CW{1'b1}}) begin
                    clr_all    = 1'b1;
                    clr_addr_d = '0;
                    state_d    = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            hit_q   <= hit_d;
        end
    end

`ifdef TRON_TRAIL_CLEAR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_addr_q <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            clr_addr_q <= clr_addr_d;
            clr_pend_q <= clr_pend_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Per-player lanes
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
        tron_trail_lane u_lane (
            .clk       (clk),
            .resetn    (resetn),
            .sel       (gnt_q == PW'(i)),
            .commit    (commit),
            .hit       (hit_q),
            .clr_all   (clr_all),
            .ack       (ack[i]),
            .collision (collision[i])
        );
    end
endmodule

// File: tb/tb_tron_trail_mem_ctrl.sv
// Bench for tron_trail_mem_ctrl: three instances (RD_LAT 2, 1, 4) with an
// arena memory each, checked against a move-level model (expected cell
// contents, collision flags, next-priority player).
module tb_tron_trail_mem_ctrl;
    localparam int NP = 2;
    localparam int XW = 4;
    localparam int YW = 3;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NI = 3;
    localparam int LAT_OF [NI] = '{2, 1, 4};

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [NP-1:0]    req       [NI];
    logic [NP*XW-1:0] pos_x     [NI];
    logic [NP*YW-1:0] pos_y     [NI];
    logic [NP-1:0]    ack       [NI];
    logic [NP-1:0]    collision [NI];
    logic             clear_start [NI];
    logic             busy      [NI];
    logic [AW-1:0]    mem_addr  [NI];
    logic             mem_re    [NI];
    logic             mem_we    [NI];
    logic [DW-1:0]    mem_wdata [NI];
    logic [DW-1:0]    mem_rdata [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int LAT = LAT_OF[k];
        bit [DW-1:0] mem   [128];
        bit [DW-1:0] rpipe [LAT];

        tron_trail_mem_ctrl #(
            .NUM_PLAYERS(NP), .X_W(XW), .Y_W(YW),
            .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)
        ) dut (
            .clk(clk), .resetn(resetn), .req(req[k]),
            .pos_x(pos_x[k]), .pos_y(pos_y[k]), .ack(ack[k]),
            .collision(collision[k]), .clear_start(clear_start[k]),
            .busy(busy[k]), .mem_addr(mem_addr[k]), .mem_re(mem_re[k]),
            .mem_we(mem_we[k]), .mem_wdata(mem_wdata[k]),
            .mem_rdata(mem_rdata[k])
        );

        // Read data is only meaningful RD_LAT cycles after a read; any other
        // cycle shows a non-zero filler so a mistimed sample looks occupied.
        always @(posedge clk) begin
            if (mem_we[k]) mem[mem_addr[k][6:0]] <= mem_wdata[k];
            rpipe[0] <= mem_re[k] ? mem[mem_addr[k][6:0]] : 16'hDEAD;
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
        assign mem_rdata[k] = rpipe[LAT-1];
    end

    // Model
    logic [DW-1:0] exp_mem  [NI][128];
    logic [NP-1:0] exp_coll [NI];
    int            exp_rr   [NI];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            exp_coll[k] = '0;
            exp_rr[k]   = 0;
        end
    endtask

    // One move on instance k with request mask rq; all req drop at ack.
    task automatic move(input int k, input logic [NP-1:0] rq,
                        input logic [NP*XW-1:0] px, input logic [NP*YW-1:0] py);
        int g, lat, re_c, we_c, ack_c, both, j;
        logic [6:0] a;
        logic [AW-1:0] re_a, we_a;
        logic [DW-1:0] we_d;
        logic [NP-1:0] ack_v;
        logic free;
        lat = LAT_OF[k];
        g = -1;
        for (int i = 0; i < NP; i++) begin
            j = (exp_rr[k] + i) % NP;
            if (g < 0 && rq[j]) g = j;
        end
        a = {px[g*XW +: XW], py[g*YW +: YW]};
        free = (exp_mem[k][a] == '0);
        re_c = -1; we_c = -1; ack_c = -1; both = 0;
        re_a = '0; we_a = '0; we_d = '0; ack_v = '0;
        @(negedge clk);
        req[k] = rq; pos_x[k] = px; pos_y[k] = py;
        for (int c = 1; c <= 12 && ack_c < 0; c++) begin
            @(negedge clk);
            if (mem_re[k] && mem_we[k]) both++;
            if (mem_re[k] && re_c < 0) begin re_c = c; re_a = mem_addr[k]; end
            if (mem_we[k] && we_c < 0) begin we_c = c; we_a = mem_addr[k]; we_d = mem_wdata[k]; end
            if (ack[k] != '0) begin ack_c = c; ack_v = ack[k]; req[k] = '0; end
        end
        req[k] = '0;
        if (free) exp_mem[k][a] = DW'(g + 1);
        else exp_coll[k][g] = 1'b1;
        exp_rr[k] = (g + 1) % NP;
        @(negedge clk);
        check($sformatf("i%0d_re_cycle", k), re_c, 1);
        check($sformatf("i%0d_re_addr", k), re_a, {1'b0, a});
        check($sformatf("i%0d_ack_cycle", k), ack_c, 2 + lat);
        check($sformatf("i%0d_ack_who", k), ack_v, 1 << g);
        check($sformatf("i%0d_we_cycle", k), we_c, free ? ack_c : -1);
        if (free) begin
            check($sformatf("i%0d_we_addr", k), we_a, {1'b0, a});
            check($sformatf("i%0d_we_data", k), we_d, g + 1);
        end
        check($sformatf("i%0d_re_we_overlap", k), both, 0);
        check($sformatf("i%0d_collision", k), collision[k], exp_coll[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ack_cyc [4];
        logic [NP-1:0] ack_who [4];
        int            na, eg, nwe, rk;
        logic [6:0]    aa;
        logic [NP-1:0] rq;
        logic [NP*XW-1:0] px;
        logic [NP*YW-1:0] py;
`ifdef TRON_TRAIL_CLEAR_EN
        int bcnt, nwr, first_b, fall_c, ack_c, ack_busy, wr_ok;
        logic [NP-1:0] coll_at_fall, ack_v;
        logic we_at_ack;
        logic [DW-1:0] wd_at_ack;
`else
        int bseen, wseen;
`endif

        // Reset
        resetn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req[k] = '0; pos_x[k] = '0; pos_y[k] = '0; clear_start[k] = 1'b0;
            for (int i = 0; i < 128; i++) exp_mem[k][i] = '0;
        end
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_ack", ack[0], 0);
        check("rst_coll", collision[0], 0);
        check("rst_re", mem_re[0], 0);
        check("rst_we", mem_we[0], 0);
        check("rst_addr", mem_addr[0], 0);
        check("rst_wdata", mem_wdata[0], 0);
        check("rst_busy", busy[0], 0);
        resetn = 1'b1;

        // Fresh cell (5,3) -> 0x2B, then collision by player 1 (twice)
        move(0, 2'b01, {4'd0, 4'd5}, {3'd0, 3'd3});
        move(0, 2'b10, {4'd5, 4'd0}, {3'd3, 3'd0});
        move(0, 2'b10, {4'd5, 4'd0}, {3'd3, 3'd0});

        // Arbitration with both requests held
        for (int i = 0; i < 4; i++) begin ack_cyc[i] = 0; ack_who[i] = '0; end
        @(negedge clk);
        req[0] = 2'b11; pos_x[0] = {4'd2, 4'd1}; pos_y[0] = {3'd2, 3'd1};
        na = 0;
        for (int c = 1; c <= 40 && na < 4; c++) begin
            @(negedge clk);
            if (ack[0] != '0) begin
                ack_cyc[na] = c; ack_who[na] = ack[0]; na++;
                if (na == 4) req[0] = '0;
            end
        end
        req[0] = '0;
        eg = exp_rr[0];
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_who%0d", i), ack_who[i], 1 << eg);
            if (i == 0) check("arb_first_ack", ack_cyc[0], 4);
            else check($sformatf("arb_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 5);
            aa = (eg == 0) ? {4'd1, 3'd1} : {4'd2, 3'd2};
            if (exp_mem[0][aa] == '0) exp_mem[0][aa] = DW'(eg + 1);
            else exp_coll[0][eg] = 1'b1;
            eg = (eg + 1) % NP;
        end
        exp_rr[0] = eg;
        @(negedge clk);
        check("arb_coll", collision[0], exp_coll[0]);

        // Latency sweep on RD_LAT=1 and RD_LAT=4 instances
        move(1, 2'b01, {4'd0, 4'd5}, {3'd0, 3'd3});
        move(1, 2'b10, {4'd5, 4'd0}, {3'd3, 3'd0});
        move(2, 2'b01, {4'd0, 4'd5}, {3'd0, 3'd3});
        move(2, 2'b11, {4'd5, 4'd6}, {3'd3, 3'd3});

        // Randomized moves in a small corner so cells collide often
        for (int n = 0; n < 12; n++) begin
            rk = int'($urandom_range(0, NI - 1));
            rq = NP'($urandom_range(1, 3));
            px = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            py = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 1))};
            move(rk, rq, px, py);
        end

        // Async reset while in WAIT on a free cell (15,7)
        check("pre_rst_coll", collision[0], exp_coll[0]);
        @(negedge clk);
        req[0] = 2'b01; pos_x[0] = {4'd0, 4'd15}; pos_y[0] = {3'd0, 3'd7};
        @(negedge clk);
        check("wait_rst_re", mem_re[0], 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("async_ack", ack[0], 0);
        check("async_coll", collision[0], 0);
        check("async_re", mem_re[0], 0);
        check("async_we", mem_we[0], 0);
        check("async_addr", mem_addr[0], 0);
        req[0] = '0;
        nwe = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_we[0]) nwe++;
        end
        check("async_no_write", nwe, 0);
        resetn = 1'b1;
        model_reset();
        // Player 0 must win first and find (15,7) still free
        move(0, 2'b11, {4'd14, 4'd15}, {3'd7, 3'd7});

`ifdef TRON_TRAIL_CLEAR_EN
        move(0, 2'b10, {4'd5, 4'd0}, {3'd3, 3'd0});
        @(negedge clk);
        clear_start[0] = 1'b1;
        bcnt = 0; nwr = 0; first_b = -1; fall_c = -1; ack_c = -1;
        ack_busy = 0; wr_ok = 1; coll_at_fall = '1; ack_v = '0;
        we_at_ack = 1'b0; wd_at_ack = '0;
        for (int c = 1; c <= 300 && ack_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) clear_start[0] = 1'b0;
            if (busy[0]) begin
                bcnt++;
                if (first_b < 0) first_b = c;
                if (!(mem_we[0] && mem_addr[0] == AW'(nwr) && mem_wdata[0] == '0)) wr_ok = 0;
                nwr++;
                if (ack[0] != '0) ack_busy = 1;
            end else if (first_b >= 0 && fall_c < 0) begin
                fall_c = c; coll_at_fall = collision[0];
            end
            if (c == 20) begin
                req[0] = 2'b01; pos_x[0] = {4'd0, 4'd1}; pos_y[0] = {3'd0, 3'd1};
            end
            if (c == 60) clear_start[0] = 1'b1;
            if (c == 61) clear_start[0] = 1'b0;
            if (ack[0] != '0 && !busy[0]) begin
                ack_c = c; ack_v = ack[0]; we_at_ack = mem_we[0];
                wd_at_ack = mem_wdata[0]; req[0] = '0;
            end
        end
        req[0] = '0;
        check("clr_first_busy", first_b, 1);
        check("clr_busy_len", bcnt, 128);
        check("clr_writes", wr_ok, 1);
        check("clr_coll_after", coll_at_fall, 0);
        check("clr_no_ack_busy", ack_busy, 0);
        check("clr_req_ack_cycle", ack_c, fall_c + 4);
        check("clr_req_ack_who", ack_v, 1);
        check("clr_req_we", we_at_ack, 1);
        check("clr_req_wdata", wd_at_ack, 1);
        for (int i = 0; i < 128; i++) exp_mem[0][i] = '0;
        exp_coll[0] = '0;
        exp_mem[0][{4'd1, 3'd1}] = 16'd1;
        exp_rr[0] = 1;
        @(negedge clk);
        check("clr_busy_low", busy[0], 0);
        move(0, 2'b10, {4'd1, 4'd0}, {3'd1, 3'd0});
`else
        @(negedge clk);
        clear_start[0] = 1'b1;
        @(negedge clk);
        clear_start[0] = 1'b0;
        bseen = 0; wseen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy[0]) bseen++;
            if (mem_we[0]) wseen++;
        end
        check("noclr_busy", bseen, 0);
        check("noclr_we", wseen, 0);
        move(0, 2'b01, {4'd0, 4'd5}, {3'd0, 3'd3});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
